// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//   Shared constants and types for the G-sensor UART receive path.
//   CLK_FREQ / BAUD_RATE / DATA_BITS describe the 8N1 link. TICK_NBR is the
//   number of system clocks per bit. HALF_TICK_NBR is the offset from the
//   falling edge of the start bit to the centre of that bit.
//   uart_rx_states enumerates the receiver FSM states.
//   No ports (package).
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int CLK_FREQ      = 5_000_000;
  localparam int BAUD_RATE     = 19200;
  localparam int DATA_BITS     = 8;
  localparam int TICK_NBR      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICK_NBR = TICK_NBR / 2;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_states;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer that brings an asynchronous single-bit input into
//   the clk domain. Both stages reset to RESET_VAL. A line that idles high
//   should therefore not show a false edge when reset is released.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     d      in   asynchronous input
//     q      out  synchronized copy of d, two clk edges later
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver. It oversamples rx with the system clock and samples
//   each bit at its centre. Each correctly framed byte is delivered as a
//   one-cycle strobe.
//   Ports:
//     clk        in   system clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     rx         in   serial line from the pin, idles high, asynchronous
//     rx_data    out  last correctly framed byte, held until the next one
//     rx_valid   out  one-cycle strobe, rx_data is new in that cycle
//     frame_err  out  one-cycle strobe, stop bit sampled low
//     busy       out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = uart_rx_pkg::CLK_FREQ,
  parameter int BAUD_RATE = uart_rx_pkg::BAUD_RATE,
  parameter int DATA_BITS = uart_rx_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  import uart_rx_pkg::*;

  localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int TICK_W     = $clog2(BIT_TICKS);
  localparam int BIT_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(HALF_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_states state_q, state_d;
  logic [TICK_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 stop_wait_q, stop_wait_d;

  // Synchronizer resets high so that an idle line is not seen as a start bit.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      stop_wait_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      stop_wait_q <= stop_wait_d;
    end
  end

  // The tick counter restarts at 0 on every state entry and after every
  // sample. It therefore only ever counts up to the next sample point.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    stop_wait_d = stop_wait_q;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d       = '0;
        bit_cnt_d   = '0;
        stop_wait_d = 1'b0;
        if (!rx_s) begin
          state_d = RX_START;
        end
      end

      // A start bit that is high again at its centre is treated as a glitch.
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + TICK_W'(1);
        end
      end

      // A right shift with new bits entering at the MSB leaves the
      // LSB-first data aligned once all bits are in.
      RX_DATA: begin
        if (cnt_q == TICK_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + TICK_W'(1);
        end
      end

      // After a framing error, stay here until the line is high again.
      // This keeps a break condition from retriggering reception.
      RX_STOP: begin
        if (stop_wait_q) begin
          cnt_d = '0;
          if (rx_s) begin
            stop_wait_d = 1'b0;
            state_d     = RX_IDLE;
          end
        end else if (cnt_q == TICK_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            stop_wait_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + TICK_W'(1);
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx at the default 5 MHz / 19200 baud.
//   Frames are driven serially on rx. Strobes are logged with their cycle
//   numbers and compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  // Strobe position relative to the cycle in which rx falls at the pin:
  // 3 edges to E0, then 130 to the start-bit centre, then 9 full bits.
  localparam int STROBE_OFS = 3 + 130 + 260 * 9;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int total;
  int bad;
  int cycle;
  int overlap;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  logic       v_busy[$];
  int         e_cyc[$];

  typedef struct {
    logic [7:0] data;
    int         ticks;
    logic [7:0] exp_data;
    int         exp_valid;
  } vec_t;

  vec_t vecs[6];

  uart_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle number; during the low phase it equals the number of
  // rising edges seen so far.
  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Strobe logger, sampled mid-cycle.
  initial overlap = 0;
  always @(negedge clk) begin
    if (rx_valid) begin
      v_cyc.push_back(cycle);
      v_dat.push_back(rx_data);
      v_busy.push_back(busy);
    end
    if (frame_err) e_cyc.push_back(cycle);
    if (rx_valid && frame_err) overlap = overlap + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic clearEvents();
    v_cyc.delete();
    v_dat.delete();
    v_busy.delete();
    e_cyc.delete();
  endtask

  // Must be called just after a rising edge; returns just after one.
  // On return the line holds the stop-bit level.
  task automatic applyStimulus(input logic [7:0] data, input int ticks,
                               input logic stop_bit, output int start);
    start = cycle;
    rx = 1'b0;
    repeat (ticks) @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) begin
      rx = data[b];
      repeat (ticks) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (ticks) @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cycle < target) @(negedge clk);
  endtask

  task automatic checkSingleByte(input string name, input int start,
                                 input logic [7:0] exp);
    checkOutput({name, " valid count"}, v_cyc.size(), 1);
    checkOutput({name, " err count"}, e_cyc.size(), 0);
    if (v_cyc.size() > 0) begin
      checkOutput({name, " strobe cycle"}, v_cyc[0], start + STROBE_OFS);
      checkOutput({name, " strobe data"}, int'(v_dat[0]), int'(exp));
      checkOutput({name, " busy at strobe"}, int'(v_busy[0]), 0);
    end
    checkOutput({name, " rx_data held"}, int'(rx_data), int'(exp));
  endtask

  initial begin
    int start;
    int s0, s1, s2;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    rx    = 1'b1;

    vecs[0] = '{8'hA5, 260, 8'hA5, 1};
    vecs[1] = '{8'hC3, 253, 8'hC3, 1};
    vecs[2] = '{8'hC3, 267, 8'hC3, 1};
    vecs[3] = '{8'h00, 260, 8'h00, 1};
    vecs[4] = '{8'hFF, 260, 8'hFF, 1};
    vecs[5] = '{8'h7E, 260, 8'h7E, 1};

    // Reset state.
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset rx_data", int'(rx_data), 0);
    checkOutput("reset rx_valid", int'(rx_valid), 0);
    checkOutput("reset frame_err", int'(frame_err), 0);
    checkOutput("reset busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle busy", int'(busy), 0);

    // Single frames: nominal rate, baud skew, and extreme data patterns.
    for (int i = 0; i < 6; i++) begin
      clearEvents();
      @(posedge clk);
      #1;
      applyStimulus(vecs[i].data, vecs[i].ticks, 1'b1, start);
      waitUntil(start + 2700);
      checkOutput($sformatf("vec%0d valid count", i), v_cyc.size(), vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d err count", i), e_cyc.size(), 0);
      if (v_cyc.size() > 0) begin
        checkOutput($sformatf("vec%0d strobe cycle", i), v_cyc[0], start + STROBE_OFS);
        checkOutput($sformatf("vec%0d strobe data", i), int'(v_dat[0]), int'(vecs[i].exp_data));
        checkOutput($sformatf("vec%0d busy at strobe", i), int'(v_busy[0]), 0);
      end
      checkOutput($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d busy after", i), int'(busy), 0);
    end

    // Glitch: a short low pulse is rejected at the start-bit centre.
    clearEvents();
    @(posedge clk);
    #1;
    start = cycle;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rx = 1'b1;
    waitUntil(start + 132);
    checkOutput("glitch busy before centre", int'(busy), 1);
    waitUntil(start + 133);
    checkOutput("glitch busy after centre", int'(busy), 0);
    waitUntil(start + 3000);
    checkOutput("glitch valid count", v_cyc.size(), 0);
    checkOutput("glitch err count", e_cyc.size(), 0);
    checkOutput("glitch rx_data", int'(rx_data), 8'h7E);

    // Framing error followed by a break, then a good frame.
    clearEvents();
    @(posedge clk);
    #1;
    applyStimulus(8'h3C, 260, 1'b0, start);
    repeat (1000) @(posedge clk);
    #1;
    checkOutput("break busy held", int'(busy), 1);
    rx = 1'b1;
    waitUntil(cycle + 300);
    checkOutput("ferr err count", e_cyc.size(), 1);
    if (e_cyc.size() > 0) checkOutput("ferr err cycle", e_cyc[0], start + STROBE_OFS);
    checkOutput("ferr valid count", v_cyc.size(), 0);
    checkOutput("ferr rx_data kept", int'(rx_data), 8'h7E);
    checkOutput("ferr busy after", int'(busy), 0);
    clearEvents();
    @(posedge clk);
    #1;
    applyStimulus(8'h5A, 260, 1'b1, start);
    waitUntil(start + 2700);
    checkSingleByte("after ferr", start, 8'h5A);

    // Back-to-back frames with no idle gap.
    clearEvents();
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 260, 1'b1, s0);
    applyStimulus(8'hFF, 260, 1'b1, s1);
    applyStimulus(8'h81, 260, 1'b1, s2);
    waitUntil(s2 + 2700);
    checkOutput("b2b valid count", v_cyc.size(), 3);
    checkOutput("b2b err count", e_cyc.size(), 0);
    if (v_cyc.size() == 3) begin
      checkOutput("b2b first cycle", v_cyc[0], s0 + STROBE_OFS);
      checkOutput("b2b data0", int'(v_dat[0]), 8'h00);
      checkOutput("b2b data1", int'(v_dat[1]), 8'hFF);
      checkOutput("b2b data2", int'(v_dat[2]), 8'h81);
      checkOutput("b2b spacing01", v_cyc[1] - v_cyc[0], 2600);
      checkOutput("b2b spacing12", v_cyc[2] - v_cyc[1], 2600);
    end

    // Reset asserted during data bit 4 of 0xF0, then 0x11.
    clearEvents();
    @(posedge clk);
    #1;
    start = cycle;
    fork
      begin
        int sdummy;
        applyStimulus(8'hF0, 260, 1'b1, sdummy);
      end
    join_none
    waitUntil(start + 1400);
    checkOutput("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset rx_data", int'(rx_data), 0);
    checkOutput("midreset rx_valid", int'(rx_valid), 0);
    checkOutput("midreset frame_err", int'(frame_err), 0);
    checkOutput("midreset busy", int'(busy), 0);
    rst_n = 1'b1;
    waitUntil(start + 2800);
    checkOutput("aborted valid count", v_cyc.size(), 0);
    checkOutput("aborted err count", e_cyc.size(), 0);
    checkOutput("aborted busy", int'(busy), 0);
    checkOutput("aborted rx_data", int'(rx_data), 0);
    clearEvents();
    @(posedge clk);
    #1;
    applyStimulus(8'h11, 260, 1'b1, start);
    waitUntil(start + 2700);
    checkSingleByte("after reset", start, 8'h11);

    checkOutput("valid/err overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART link of the DE0-Nano G-sensor design, the receive-side counterpart of the existing UART transmitter. It oversamples the `rx` pin with the system clock, recovers 8N1 frames at the baud rate defined in `pkg`, and delivers each byte as a one-cycle strobe. It sits between the board RX pin and the command/control logic that configures the accelerometer SPI engine.

## Interface
- `CLK_FREQ`, default `pkg::CLK_FREQ` (5_000_000): system clock frequency in Hz.
- `BAUD_RATE`, default `pkg::BAUD_RATE` (19200): line rate in baud.
- `DATA_BITS`, default `pkg::DATA_BITS` (8): data bits per frame, sent LSB first.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line from the pin; asynchronous to `clk`, idles high.
- `rx_data`  out  DATA_BITS  last correctly framed byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is new in that cycle.
- `frame_err`  out  1  one-cycle strobe; stop bit was sampled low.
- `busy`  out  1  high whenever FSM is not in RX_IDLE.

## Operation
- Input synchronizer: two flops, both reset to 1. The FSM sees only the synchronized signal `rx_s`.
- Bit period: `TICK_NBR = CLK_FREQ/BAUD_RATE`, integer division (260 at defaults). Half period: `HALF_TICK = TICK_NBR/2` (130).
- Tick counter: width `$clog2(TICK_NBR)`. It is cleared on every state entry and after every sample, and it never wraps past `TICK_NBR-1`. Bit counter: width `$clog2(DATA_BITS)`.
- FSM states and transitions:
  - RX_IDLE: go to RX_START when `rx_s==0`.
  - RX_START: when count == `HALF_TICK-1`, sample `rx_s`. If 0, clear the counter and go to RX_DATA. If 1, treat it as a glitch and return to RX_IDLE with no strobe.
  - RX_DATA: when count == `TICK_NBR-1`, shift `rx_s` into the MSB of the shift register (a right shift, so LSB-first bits end up aligned). After `DATA_BITS` samples, go to RX_STOP.
  - RX_STOP: when count == `TICK_NBR-1`, sample `rx_s`.
    - If 1: load `rx_data` from the shift register, pulse `rx_valid`, go to RX_IDLE.
    - If 0: pulse `frame_err` and leave `rx_data` unchanged. Stay in RX_STOP until `rx_s==1`, then go to RX_IDLE. This stops a break condition from retriggering.
- Only one stop bit is checked. Extra stop bits look like idle line.
- `rx_valid` and `frame_err` are never high in the same cycle.
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, FSM=RX_IDLE, counters=0, synchronizer=1.
- Reset asserted mid-frame: the frame is aborted immediately and no strobe is issued. After release, reception restarts only on a new falling edge of `rx_s`.

## Timing
- E0 is the clock edge at which the FSM leaves RX_IDLE. E0 falls 3 edges after `rx` goes low at the pin: 2 synchronizer edges plus 1 detect edge.
- Sample edges:
  - Start bit: E0+`HALF_TICK` (130).
  - Data bit k (0-based): E0+`HALF_TICK`+`TICK_NBR`·(k+1), i.e. 390 … 2210.
  - Stop bit: E0+`HALF_TICK`+`TICK_NBR`·(DATA_BITS+1) = E0+2470.
- `rx_valid`/`frame_err` rise on the stop-sample edge and stay high for exactly one cycle. `rx_data` updates on that same edge.
- Back-to-back frames: a new start bit can be detected in the cycle after the FSM returns to RX_IDLE. With one stop bit at nominal rate, the next start is still caught in time.
- Tolerance: bits are sampled at the centre of each bit, so the block receives correctly with up to ±3% baud mismatch.

## Structure
- Add to `pkg`:
  - typedef enum `uart_rx_states {RX_IDLE, RX_START, RX_DATA, RX_STOP}`.
  - constant `HALF_TICK_NBR = TICK_NBR/2`.
- Reuse `DATA_BITS`, `CLK_FREQ`, `BAUD_RATE`, `TICK_NBR` from `pkg`.
- Sub-module `sync_2ff` (parameter `RESET_VAL`) for the input synchronizer. Everything else lives in `uart_rx`: FSM, counters and shift register.

## Test plan
- Nominal byte: drive 0xA5, 8N1, 260 clk/bit → `rx_data`=0xA5, `rx_valid` one-cycle pulse at E0+2470, `busy` low the next cycle.
- Glitch: `rx` low for 50 cycles then high → no `rx_valid`/`frame_err`, FSM back to RX_IDLE at E0+130.
- Framing error: 0x3C with stop bit low, line held low 1000 cycles, then 0x5A sent normally → single `frame_err` pulse, `rx_data` stays at the previous value, then `rx_valid` with 0x5A.
- Back-to-back: 0x00, 0xFF, 0x81 with one stop bit each, no idle gap → three `rx_valid` pulses with the correct bytes, 2600 cycles apart.
- Baud skew: 0xC3 sent at 253 and 267 clk/bit → `rx_data`=0xC3 in both cases.
- Reset mid-frame: `rst_n` low during data bit 4 of 0xF0, released, then 0x11 sent → no strobe for the aborted frame, outputs at reset values, then `rx_data`=0x11.
